// File: rtl/muldiv_sequencer.sv
// RV32M multiply/divide sequencer: 32-step shift-add multiplier and restoring
// divider that stalls the pipeline while busy and emits a one-cycle done pulse.
module muldiv_sequencer #(
  parameter bit FAST_SPECIAL = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        flush,
  output logic        stall_wire,
  output logic        done_wire,
  output logic [31:0] result_wire
);

  typedef enum logic [2:0] {IDLE, PREP, CALC, FIXUP, DONE} state_t;

  state_t      state, state_next;
  logic [31:0] a_reg, b_reg, addend, shifter;
  logic [2:0]  op_reg;
  logic [63:0] acc;
  logic [4:0]  count;
  logic        neg_res, a_neg;

  logic        is_div, a_signed, b_signed, a_is_neg, b_is_neg;
  logic        div_zero, div_ovf, special;
  logic [31:0] mag_a, mag_b, special_res, quo, rem, fixup_res;
  logic [63:0] prod;
  logic [32:0] mul_sum, rem_sh, trial;

  always_comb begin
    is_div   = op_reg[2];
    a_signed = (op_reg == 3'b001) || (op_reg == 3'b010) || (op_reg == 3'b100) || (op_reg == 3'b110);
    b_signed = (op_reg == 3'b001) || (op_reg == 3'b100) || (op_reg == 3'b110);
    a_is_neg = a_signed && a_reg[31];
    b_is_neg = b_signed && b_reg[31];
    mag_a    = a_is_neg ? (~a_reg + 32'd1) : a_reg;
    mag_b    = b_is_neg ? (~b_reg + 32'd1) : b_reg;
    div_zero = is_div && (b_reg == 32'd0);
    div_ovf  = is_div && !op_reg[0] && (a_reg == 32'h8000_0000) && (b_reg == 32'hFFFF_FFFF);
    special  = div_zero || div_ovf;
    if (div_zero) special_res = op_reg[1] ? a_reg : 32'hFFFF_FFFF;
    else          special_res = op_reg[1] ? 32'd0 : 32'h8000_0000;
  end

  // One iteration of each algorithm, plus the sign fix-up and word select.
  always_comb begin
    mul_sum = {1'b0, acc[63:32]} + {1'b0, (shifter[0] ? addend : 32'd0)};
    rem_sh  = {acc[63:32], shifter[31]};
    trial   = rem_sh - {1'b0, addend};
    prod    = neg_res ? (~acc + 64'd1) : acc;
    quo     = neg_res ? (~acc[31:0] + 32'd1) : acc[31:0];
    rem     = a_neg ? (~acc[63:32] + 32'd1) : acc[63:32];
    case (op_reg)
      3'b000:                 fixup_res = prod[31:0];
      3'b001, 3'b010, 3'b011: fixup_res = prod[63:32];
      3'b100, 3'b101:         fixup_res = quo;
      default:                fixup_res = rem;
    endcase
    if (special) fixup_res = special_res;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = PREP;
      PREP:    state_next = (FAST_SPECIAL && special) ? DONE : CALC;
      CALC:    if (count == 5'd0) state_next = FIXUP;
      FIXUP:   state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (flush) state_next = IDLE;
    stall_wire = !flush && ((state == IDLE && start) || state == PREP ||
                            state == CALC || state == FIXUP);
    done_wire  = !flush && (state == DONE);
  end

  // Multiply keeps the multiplicand in addend and shifts the multiplier right;
  // divide keeps the divisor in addend and shifts dividend bits in from the top.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg       <= '0;
      b_reg       <= '0;
      op_reg      <= '0;
      addend      <= '0;
      shifter     <= '0;
      acc         <= '0;
      count       <= '0;
      neg_res     <= 1'b0;
      a_neg       <= 1'b0;
      result_wire <= '0;
    end else if (!flush) begin
      case (state)
        IDLE: begin
          if (start) begin
            a_reg  <= A;
            b_reg  <= B;
            op_reg <= md_op;
          end
        end
        PREP: begin
          neg_res <= a_is_neg ^ b_is_neg;
          a_neg   <= a_is_neg;
          acc     <= '0;
          count   <= 5'd31;
          addend  <= is_div ? mag_b : mag_a;
          shifter <= is_div ? mag_a : mag_b;
          if (FAST_SPECIAL && special) result_wire <= special_res;
        end
        CALC: begin
          count <= count - 5'd1;
          if (is_div) begin
            shifter <= {shifter[30:0], 1'b0};
            if (!trial[32]) acc <= {trial[31:0], acc[30:0], 1'b1};
            else            acc <= {rem_sh[31:0], acc[30:0], 1'b0};
          end else begin
            shifter <= {1'b0, shifter[31:1]};
            acc     <= {mul_sum, acc[31:1]};
          end
        end
        FIXUP:   result_wire <= fixup_res;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: one fast-special and one iterating
// instance, checked for results, latency, stall, flush and reset behaviour.
module tb_muldiv_sequencer;

  localparam logic [2:0] OP_MUL = 3'b000, OP_MULH = 3'b001, OP_MULHSU = 3'b010, OP_MULHU = 3'b011;
  localparam logic [2:0] OP_DIV = 3'b100, OP_DIVU = 3'b101, OP_REM = 3'b110, OP_REMU = 3'b111;

  logic        clk = 1'b0;
  logic        rst_n, start_f, start_s, flush;
  logic [2:0]  md_op;
  logic [31:0] A, B;
  logic        stall_f, done_f, stall_s, done_s;
  logic [31:0] result_f, result_s;
  logic        done_seen;
  int          applied = 0;
  int          miscompares = 0;

  always #5 clk = ~clk;

  muldiv_sequencer #(.FAST_SPECIAL(1'b1)) dut_fast (
    .clk(clk), .rst_n(rst_n), .start(start_f), .md_op(md_op), .A(A), .B(B), .flush(flush),
    .stall_wire(stall_f), .done_wire(done_f), .result_wire(result_f)
  );

  muldiv_sequencer #(.FAST_SPECIAL(1'b0)) dut_slow (
    .clk(clk), .rst_n(rst_n), .start(start_s), .md_op(md_op), .A(A), .B(B), .flush(flush),
    .stall_wire(stall_s), .done_wire(done_s), .result_wire(result_s)
  );

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    applied++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Raises start in the current cycle T, scrambles the operand inputs once the
  // op is accepted, and waits (bounded) for done to check latency and result.
  task automatic apply_op(input bit slow, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat,
                          input bit hold_start, input string tag);
    int   n;
    bit   stall_gap;
    logic busy, fin;
    @(negedge clk);
    md_op = op;
    A     = a;
    B     = b;
    if (slow) start_s = 1'b1;
    else      start_f = 1'b1;
    #1;
    check_output({tag, " stall@T"}, 32'(slow ? stall_s : stall_f), 32'd1);
    n = 0;
    stall_gap = 1'b0;
    busy = 1'b1;
    fin = 1'b0;
    while (!fin && n < 80) begin
      @(negedge clk);
      n++;
      if (n == 2) begin
        md_op = ~op;
        A     = ~a;
        B     = b ^ 32'h0000_0013;
      end
      #1;
      fin  = slow ? done_s : done_f;
      busy = slow ? stall_s : stall_f;
      if (!fin && !busy) stall_gap = 1'b1;
    end
    check_output({tag, " latency"}, 32'(n), 32'(exp_lat));
    check_output({tag, " stall gap"}, 32'(stall_gap), 32'd0);
    check_output({tag, " stall@done"}, 32'(busy), 32'd0);
    check_output({tag, " result"}, slow ? result_s : result_f, exp_res);
    if (!hold_start) begin
      start_f = 1'b0;
      start_s = 1'b0;
    end
  endtask

  initial begin
    rst_n = 1'b0; start_f = 1'b0; start_s = 1'b0; flush = 1'b0;
    md_op = '0; A = '0; B = '0;
    #1;
    check_output("reset result_f", result_f, 32'd0);
    check_output("reset result_s", result_s, 32'd0);
    check_output("reset done", 32'({done_f, done_s}), 32'd0);
    check_output("reset stall", 32'({stall_f, stall_s}), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    apply_op(0, OP_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 35, 0, "mul");
    apply_op(0, OP_MULH,   32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFFF, 35, 0, "mulh");
    apply_op(0, OP_MULHU,  32'd7,          32'hFFFF_FFFD, 32'h0000_0006, 35, 0, "mulhu");
    apply_op(0, OP_DIV,    32'hFFFF_FFEC,  32'd6,         32'hFFFF_FFFD, 35, 0, "div");
    apply_op(0, OP_REM,    32'hFFFF_FFEC,  32'd6,         32'hFFFF_FFFE, 35, 0, "rem");
    apply_op(0, OP_DIVU,   32'd20,         32'd6,         32'd3,         35, 0, "divu");
    apply_op(0, OP_REMU,   32'd20,         32'd6,         32'd2,         35, 0, "remu");
    apply_op(0, OP_DIV,    32'd20,         32'hFFFF_FFFA, 32'hFFFF_FFFD, 35, 0, "div pos/neg");
    apply_op(0, OP_REM,    32'd20,         32'hFFFF_FFFA, 32'd2,         35, 0, "rem pos/neg");
    apply_op(0, OP_MULH,   32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 35, 0, "mulh minmin");
    apply_op(0, OP_MULHSU, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 35, 0, "mulhsu min");

    apply_op(0, OP_DIVU,   32'd5,          32'd0,         32'hFFFF_FFFF, 2, 0, "fast divu0");
    apply_op(0, OP_REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         2, 0, "fast rem ovf");
    apply_op(0, OP_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 2, 0, "fast div ovf");
    apply_op(0, OP_REMU,   32'd5,          32'd0,         32'd5,         2, 0, "fast remu0");
    apply_op(0, OP_REM,    32'hFFFF_FFEC,  32'd0,         32'hFFFF_FFEC, 2, 0, "fast rem0");

    apply_op(1, OP_DIVU,   32'd5,          32'd0,         32'hFFFF_FFFF, 35, 0, "slow divu0");
    apply_op(1, OP_REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         35, 0, "slow rem ovf");
    apply_op(1, OP_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 35, 0, "slow div ovf");
    apply_op(1, OP_REM,    32'hFFFF_FFEC,  32'd0,         32'hFFFF_FFEC, 35, 0, "slow rem0");
    apply_op(1, OP_DIV,    32'hFFFF_FFEC,  32'd0,         32'hFFFF_FFFF, 35, 0, "slow div0");

    apply_op(0, OP_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 35, 0, "mulhsu ones");
    apply_op(0, OP_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 35, 0, "mulhu ones");

    // start together with flush in IDLE must not be accepted
    @(negedge clk);
    start_f = 1'b1; flush = 1'b1; md_op = OP_MUL; A = 32'd3; B = 32'd3;
    #1;
    check_output("idle flush stall", 32'(stall_f), 32'd0);
    @(negedge clk);
    start_f = 1'b0; flush = 1'b0;
    #1;
    check_output("idle flush not taken", 32'(stall_f), 32'd0);

    // flush ten cycles into a divide
    @(negedge clk);
    md_op = OP_DIV; A = 32'd100; B = 32'd7; start_f = 1'b1;
    repeat (10) @(negedge clk);
    flush = 1'b1; start_f = 1'b0;
    #1;
    check_output("flush stall same cycle", 32'(stall_f), 32'd0);
    check_output("flush done same cycle", 32'(done_f), 32'd0);
    @(negedge clk);
    flush = 1'b0;
    #1;
    check_output("flush stall after", 32'(stall_f), 32'd0);
    check_output("flush result kept", result_f, 32'hFFFF_FFFE);
    done_seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      #1;
      if (done_f) done_seen = 1'b1;
    end
    check_output("flush no done", 32'(done_seen), 32'd0);
    check_output("flush result still kept", result_f, 32'hFFFF_FFFE);
    apply_op(0, OP_DIV, 32'd100, 32'd7, 32'd14, 35, 0, "div after flush");

    // asynchronous reset twenty cycles into a multiply
    @(negedge clk);
    md_op = OP_MUL; A = 32'd9; B = 32'd9; start_f = 1'b1;
    repeat (20) @(negedge clk);
    rst_n = 1'b0; start_f = 1'b0;
    #1;
    check_output("midop reset result_f", result_f, 32'd0);
    check_output("midop reset result_s", result_s, 32'd0);
    check_output("midop reset done", 32'(done_f), 32'd0);
    check_output("midop reset stall", 32'(stall_f), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    apply_op(0, OP_MUL, 32'd7, 32'd3, 32'd21, 35, 0, "mul after reset");

    // back-to-back: start held through DONE, next op taken the following cycle
    apply_op(0, OP_MULHU, 32'h0001_0000, 32'h0001_0000, 32'd1, 35, 1, "b2b mulhu");
    apply_op(0, OP_DIV,   32'd100,       32'hFFFF_FFF9, 32'hFFFF_FFF2, 35, 0, "b2b div");
    apply_op(0, OP_MUL,   32'h1234_5678, 32'h0000_0010, 32'h2345_6780, 35, 0, "mul shift");

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
